id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 63 ++++++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-slot fields, squash control, the two
// downstream forwarding sources, and the execute-side outputs of the stage.
interface id_ex_stage_if;
    // decode slot
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_operation;
    logic        id_alu_src;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;

    // squash from branch/jump resolution
    logic        flush;

    // forwarding sources
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [31:0] memwb_result;

    // execute-side outputs
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_alu_src;
    logic [4:0]  ex_operation;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        stall_id;

    // pipeline control side: drives decode/forwarding, consumes EX outputs
    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_operation, id_alu_src,
               id_rd, id_reg_write, id_mem_read, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_alu_src, ex_operation,
               ex_rd, ex_imm, ex_rs1, ex_rs2, stall_id
    );

    // the ID/EX stage itself
    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_operation, id_alu_src,
               id_rd, id_reg_write, id_mem_read, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        output ex_valid, ex_reg_write, ex_mem_read, ex_alu_src, ex_operation,
               ex_rd, ex_imm, ex_rs1, ex_rs2, stall_id
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, capture-time
// write-back bypass and execute-operand forwarding from EX/MEM and MEM/WB.
// Register x0 is hardwired zero and is never a forwarding/bypass target.
module id_ex_stage (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic        valid_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic        alu_src_q;
    logic [4:0]  operation_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;

    logic        hazard;
    logic        wb_hit_rs1;
    logic        wb_hit_rs2;
    logic [31:0] rs1_capture;
    logic [31:0] rs2_capture;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    // load in EX whose destination is a source the decode slot actually reads
    always_comb begin
        hazard = 1'b0;
        if (valid_q && mem_read_q && (rd_q != 5'd0) && bus.id_valid) begin
            hazard = (bus.id_uses_rs1 && (bus.id_rs1_addr == rd_q)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2_addr == rd_q));
        end
    end

    // a flush squashes the offending decode slot, so no hold is needed
    assign bus.stall_id = hazard & ~bus.flush;

    // register file write in the same cycle is not yet visible in its read data
    always_comb begin
        wb_hit_rs1  = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) &&
                      (bus.memwb_rd == bus.id_rs1_addr);
        wb_hit_rs2  = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) &&
                      (bus.memwb_rd == bus.id_rs2_addr);
        rs1_capture = wb_hit_rs1 ? bus.memwb_result : bus.id_rs1_data;
        rs2_capture = wb_hit_rs2 ? bus.memwb_result : bus.id_rs2_data;
    end

    // pipeline register: flush and bubble both clear, otherwise capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_src_q   <= 1'b0;
            operation_q <= 5'd0;
            rd_q        <= 5'd0;
            imm_q       <= 32'd0;
            rs1_addr_q  <= 5'd0;
            rs2_addr_q  <= 5'd0;
            rs1_data_q  <= 32'd0;
            rs2_data_q  <= 32'd0;
        end else if (bus.flush || hazard) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_src_q   <= 1'b0;
            operation_q <= 5'd0;
            rd_q        <= 5'd0;
            imm_q       <= 32'd0;
            rs1_addr_q  <= 5'd0;
            rs2_addr_q  <= 5'd0;
            rs1_data_q  <= 32'd0;
            rs2_data_q  <= 32'd0;
        end else begin
            valid_q     <= bus.id_valid;
            reg_write_q <= bus.id_reg_write;
            mem_read_q  <= bus.id_mem_read;
            alu_src_q   <= bus.id_alu_src;
            operation_q <= bus.id_operation;
            rd_q        <= bus.id_rd;
            imm_q       <= bus.id_imm;
            rs1_addr_q  <= bus.id_rs1_addr;
            rs2_addr_q  <= bus.id_rs2_addr;
            rs1_data_q  <= rs1_capture;
            rs2_data_q  <= rs2_capture;
        end
    end

    // operand forwarding: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs1_addr_q)) begin
            rs1_fwd = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs1_addr_q)) begin
            rs1_fwd = bus.memwb_result;
        end

        rs2_fwd = rs2_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs2_addr_q)) begin
            rs2_fwd = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs2_addr_q)) begin
            rs2_fwd = bus.memwb_result;
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_reg_write = reg_write_q;
    assign bus.ex_mem_read  = mem_read_q;
    assign bus.ex_alu_src   = alu_src_q;
    assign bus.ex_operation = operation_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs1       = rs1_fwd;
    assign bus.ex_rs2       = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: expected EX-stage contents are queued when the
// decode slot is driven and popped/compared after the capturing edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        as;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage_if bus();

    id_ex_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.id_valid        = 1'b0;
        bus.id_rs1_addr     = 5'd0;
        bus.id_rs2_addr     = 5'd0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.id_rs1_data     = 32'd0;
        bus.id_rs2_data     = 32'd0;
        bus.id_imm          = 32'd0;
        bus.id_operation    = 5'd0;
        bus.id_alu_src      = 1'b0;
        bus.id_rd           = 5'd0;
        bus.id_reg_write    = 1'b0;
        bus.id_mem_read     = 1'b0;
        bus.flush           = 1'b0;
        bus.exmem_rd        = 5'd0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_result    = 32'd0;
        bus.memwb_rd        = 5'd0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_result    = 32'd0;
    endtask

    task automatic drive_id(input logic [4:0] rs1a, input logic [4:0] rs2a,
                            input logic [31:0] rs1d, input logic [31:0] rs2d,
                            input logic [31:0] imm, input logic [4:0] op, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic as,
                            input logic u1, input logic u2);
        bus.id_valid     = 1'b1;
        bus.id_rs1_addr  = rs1a;
        bus.id_rs2_addr  = rs2a;
        bus.id_rs1_data  = rs1d;
        bus.id_rs2_data  = rs2d;
        bus.id_imm       = imm;
        bus.id_operation = op;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_alu_src   = as;
        bus.id_uses_rs1  = u1;
        bus.id_uses_rs2  = u2;
    endtask

    task automatic push_capture(input logic [31:0] rs1e, input logic [31:0] rs2e);
        exp_t e;
        e.valid = bus.id_valid;
        e.rw    = bus.id_reg_write;
        e.mr    = bus.id_mem_read;
        e.as    = bus.id_alu_src;
        e.op    = bus.id_operation;
        e.rd    = bus.id_rd;
        e.imm   = bus.id_imm;
        e.rs1   = rs1e;
        e.rs2   = rs2e;
        exp_q.push_back(e);
    endtask

    task automatic push_bubble();
        exp_t e;
        e = '0;
        exp_q.push_back(e);
    endtask

    // one edge; forwarding sources are quiesced so ex_rs shows the registered data
    task automatic step_compare(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        bus.exmem_reg_write = 1'b0;
        bus.memwb_reg_write = 1'b0;
        bus.flush           = 1'b0;
        #1;
        chk({tag, "_sb_depth"}, exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, bus.ex_valid, e.valid);
            chk({tag, "_reg_write"}, bus.ex_reg_write, e.rw);
            chk({tag, "_mem_read"}, bus.ex_mem_read, e.mr);
            chk({tag, "_alu_src"}, bus.ex_alu_src, e.as);
            chk({tag, "_op"}, bus.ex_operation, e.op);
            chk({tag, "_rd"}, bus.ex_rd, e.rd);
            chk({tag, "_imm"}, bus.ex_imm, e.imm);
            chk({tag, "_rs1"}, bus.ex_rs1, e.rs1);
            chk({tag, "_rs2"}, bus.ex_rs2, e.rs2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d1;
        logic [31:0] d2;

        set_idle();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", bus.ex_valid, 32'd0);
        chk("rst_stall", bus.stall_id, 32'd0);
        chk("rst_rs1", bus.ex_rs1, 32'd0);
        chk("rst_imm", bus.ex_imm, 32'd0);
        #1;
        rst_n = 1'b1;

        // basic capture with immediate operand
        drive_id(5'd1, 5'd2, 32'd5, 32'd9, 32'd7, 5'b00000, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        push_capture(32'd5, 32'd9);
        step_compare("cap");

        // back-to-back captures, no hazards, no forwarding
        for (int i = 0; i < 6; i++) begin
            d1 = $urandom;
            d2 = $urandom;
            drive_id(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), d1, d2, $urandom,
                     5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                     1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            push_capture(d1, d2);
            step_compare("b2b");
        end

        // forwarding priority on rs1 = x3
        drive_id(5'd3, 5'd8, 32'h11, 32'h22, 32'd0, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        push_capture(32'h11, 32'h22);
        step_compare("fwdcap");
        bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA; bus.exmem_reg_write = 1'b1;
        bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB; bus.memwb_reg_write = 1'b1;
        #1;
        chk("fwd_exmem_prio", bus.ex_rs1, 32'hAA);
        chk("fwd_rs2_untouched", bus.ex_rs2, 32'h22);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("fwd_memwb", bus.ex_rs1, 32'hBB);
        bus.memwb_reg_write = 1'b0;

        // capture-time write-back bypass on rs2 = x5
        drive_id(5'd10, 5'd5, 32'h3, 32'h1234, 32'd0, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.memwb_rd = 5'd5; bus.memwb_result = 32'hCAFE; bus.memwb_reg_write = 1'b1;
        push_capture(32'h3, 32'hCAFE);
        step_compare("wbbyp");

        // x0 never bypassed at capture nor forwarded
        drive_id(5'd0, 5'd0, 32'd0, 32'h9, 32'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.memwb_rd = 5'd0; bus.memwb_result = 32'h55; bus.memwb_reg_write = 1'b1;
        push_capture(32'd0, 32'h9);
        step_compare("x0cap");
        bus.exmem_rd = 5'd0; bus.exmem_result = 32'h77; bus.exmem_reg_write = 1'b1;
        bus.memwb_rd = 5'd0; bus.memwb_result = 32'h66; bus.memwb_reg_write = 1'b1;
        #1;
        chk("x0_fwd_rs1", bus.ex_rs1, 32'd0);
        chk("x0_fwd_rs2", bus.ex_rs2, 32'h9);
        bus.exmem_reg_write = 1'b0;
        bus.memwb_reg_write = 1'b0;

        // load-use: load to x4 in EX, ID reads x4 via rs2
        drive_id(5'd1, 5'd2, 32'h0, 32'h0, 32'h40, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_capture(32'h0, 32'h0);
        step_compare("ld");
        drive_id(5'd13, 5'd4, 32'h1, 32'h0BAD, 32'd0, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_unused_nostall", bus.stall_id, 32'd0);
        bus.id_uses_rs2 = 1'b1;
        #1;
        chk("lu_stall", bus.stall_id, 32'd1);
        push_bubble();
        step_compare("lu_bubble");
        chk("lu_stall_released", bus.stall_id, 32'd0);
        push_capture(32'h1, 32'h0BAD);
        step_compare("lu_recap");
        bus.memwb_rd = 5'd4; bus.memwb_result = 32'hDEAD; bus.memwb_reg_write = 1'b1;
        #1;
        chk("lu_load_fwd", bus.ex_rs2, 32'hDEAD);
        bus.memwb_reg_write = 1'b0;

        // flush overrides a load-use hazard
        drive_id(5'd1, 5'd2, 32'h0, 32'h0, 32'h8, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        push_capture(32'h0, 32'h0);
        step_compare("ld2");
        drive_id(5'd7, 5'd15, 32'h44, 32'h45, 32'h5, 5'd6, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("fl_hazard_stall", bus.stall_id, 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall_masked", bus.stall_id, 32'd0);
        push_bubble();
        step_compare("flush");

        // reset mid-stall clears the bubble; first edge after release captures
        drive_id(5'd1, 5'd2, 32'h0, 32'h0, 32'h8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        push_capture(32'h0, 32'h0);
        step_compare("ld3");
        drive_id(5'd9, 5'd17, 32'h71, 32'h72, 32'h73, 5'd5, 5'd18, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("rs_stall_before", bus.stall_id, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_valid", bus.ex_valid, 32'd0);
        chk("rs_stall", bus.stall_id, 32'd0);
        chk("rs_mem_read", bus.ex_mem_read, 32'd0);
        rst_n = 1'b1;
        push_capture(32'h71, 32'h72);
        step_compare("rs_recap");

        // async reset between edges while ex_valid = 1
        chk("ar_valid_before", bus.ex_valid, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.ex_valid, 32'd0);
        chk("ar_reg_write", bus.ex_reg_write, 32'd0);
        chk("ar_op", bus.ex_operation, 32'd0);
        chk("ar_rd", bus.ex_rd, 32'd0);
        chk("ar_imm", bus.ex_imm, 32'd0);
        chk("ar_rs1", bus.ex_rs1, 32'd0);
        chk("ar_rs2", bus.ex_rs2, 32'd0);
        rst_n = 1'b1;
        set_idle();
        push_bubble();
        step_compare("idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
